branch_target_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the fetch stage. Each cycle it looks up the current fetch PC and drives the `prediction` / `control_pc` pair that fetch uses to pick its next PC. The EX stage writes resolved branch outcomes back into it, which are visible to lookups from the following cycle.

---
 rtl/branch_target_predictor.sv | 103 ++++++++++
 tb/tb_branch_target_predictor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit direction counters
// Optional statistics counters: BTP_STATS_EN
module branch_target_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpc,
    input  logic        stall,
    output logic        prediction,
    output logic [31:0] control_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_predicted
`ifdef BTP_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic             valid_q  [ENTRIES];
    logic [TAGW-1:0]  tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX-1:0]   l_idx;
    logic [TAGW-1:0]  l_tag;
    logic             l_hit;

    logic [IDX-1:0]   u_idx;
    logic [TAGW-1:0]  u_tag;
    logic             u_hit;
    logic [1:0]       u_ctr;
    logic [1:0]       u_ctr_next;

    logic             unused_bits;
    assign unused_bits = ^{stall, upd_predicted, cpc[1:0], upd_pc[1:0]};

    // Lookup reads the table as it stands before this edge's update.
    always_comb begin
        l_idx      = cpc[IDX+1:2];
        l_tag      = cpc[31:2+IDX];
        l_hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        prediction = l_hit && ctr_q[l_idx][1] && !rst;
        control_pc = prediction ? target_q[l_idx] : cpc + 32'd4;
    end

    always_comb begin
        u_idx = upd_pc[IDX+1:2];
        u_tag = upd_pc[31:2+IDX];
        u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_ctr = ctr_q[u_idx];
        u_ctr_next = u_ctr;
        if (upd_taken) begin
            if (u_ctr != 2'b11) u_ctr_next = u_ctr + 2'b01;
        end else begin
            if (u_ctr != 2'b00) u_ctr_next = u_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_next;
                if (upd_taken) target_q[u_idx] <= upd_target;
            end else if (upd_taken) begin
                // Allocation evicts whatever aliasing entry held this index.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_idx]    <= 2'b10;
            end
        end
    end

`ifdef BTP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= 32'd0;
            stat_updates     <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (!stall)    stat_lookups <= stat_lookups + 32'd1;
            if (upd_valid) stat_updates <= stat_updates + 32'd1;
            if (upd_valid && (upd_predicted != upd_taken))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpc;
    logic        stall;
    logic        prediction;
    logic [31:0] control_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_predicted;
`ifdef BTP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(.ENTRIES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpc           (cpc),
        .stall         (stall),
        .prediction    (prediction),
        .control_pc    (control_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_predicted (upd_predicted)
`ifdef BTP_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_pred,
                        input logic [31:0] exp_cp);
        cpc = pc;
        #1;
        check_eq({tag, "_pred"}, {31'd0, prediction}, {31'd0, exp_pred});
        check_eq({tag, "_cpc"}, control_pc, exp_cp);
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cpc = 32'h100; stall = 1'b0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        upd_target = 32'h0; upd_predicted = 1'b0;
        @(negedge clk);
        look("in_reset", 32'h100, 1'b0, 32'h104);
        tick();
        rst = 1'b0;
        tick();
        look("post_reset", 32'h100, 1'b0, 32'h104);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        do_upd(32'h100, 1'b1, 32'h200);
        look("alloc_hit", 32'h100, 1'b1, 32'h200);
        look("alias_miss", 32'h140, 1'b0, 32'h144);
        look("low_bits_ignored", 32'h103, 1'b1, 32'h200);

        for (int i = 0; i < 3; i++) do_upd(32'h100, 1'b1, 32'h200);
        look("sat_hi", 32'h100, 1'b1, 32'h200);
        do_upd(32'h100, 1'b0, 32'h999);
        look("dec_one", 32'h100, 1'b1, 32'h200);
        do_upd(32'h100, 1'b0, 32'h999);
        look("dec_two", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b1, 32'h888);
        look("reinc", 32'h100, 1'b1, 32'h888);
        do_upd(32'h102, 1'b1, 32'h300);
        look("new_target", 32'h100, 1'b1, 32'h300);

        cpc = 32'h104;
        upd_valid = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1; upd_target = 32'h400;
        look("same_cycle_old", 32'h104, 1'b0, 32'h108);
        tick();
        upd_valid = 1'b0;
        look("same_cycle_new", 32'h104, 1'b1, 32'h400);

        do_upd(32'h144, 1'b1, 32'h500);
        look("evicted", 32'h104, 1'b0, 32'h108);
        look("evictor", 32'h144, 1'b1, 32'h500);

        do_upd(32'h10C, 1'b0, 32'h600);
        look("miss_nt", 32'h10C, 1'b0, 32'h110);

        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h108; upd_taken = 1'b1; upd_target = 32'h600;
        tick();
        upd_valid = 1'b0;
        look("rst_gate", 32'h144, 1'b0, 32'h148);
        rst = 1'b0;
        look("rst_upd", 32'h108, 1'b0, 32'h10C);
        look("rst_clr", 32'h144, 1'b0, 32'h148);
        look("rst_clr2", 32'h100, 1'b0, 32'h104);

`ifdef BTP_STATS_EN
        rst = 1'b1;
        tick();
        check_eq("stat_lk_rst", stat_lookups, 32'd0);
        check_eq("stat_up_rst", stat_updates, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b1;
        tick();
        tick();
        check_eq("stat_lookups", stat_lookups, 32'd5);
        upd_predicted = 1'b1; do_upd(32'h700, 1'b0, 32'h0);
        upd_predicted = 1'b0; do_upd(32'h700, 1'b0, 32'h0);
        upd_predicted = 1'b0; do_upd(32'h704, 1'b1, 32'h800);
        tick();
        check_eq("stat_updates", stat_updates, 32'd3);
        check_eq("stat_mispredicts", stat_mispredicts, 32'd2);
        check_eq("stat_lk_stalled", stat_lookups, 32'd5);
        stall = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
